// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_arbiter
// Description : Shares the memory bus between the CPU and a page-to-port DMA
//               copy engine. Optional build macro: DMA_PARITY_ALIGN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_arbiter #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004,
    parameter int unsigned XFER_LEN  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_ready,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam logic [8:0] C_LAST_IDX = 9'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PENDING = 3'd1,
        S_HALT    = 3'd2,
        S_RD      = 3'd3,
        S_WR      = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [8:0] r_idx;
    logic [8:0] w_idx_nxt;
    logic [7:0] r_page;
    logic [7:0] w_page_nxt;
    logic [7:0] r_byte;
    logic       r_cpu_ready;
    logic       w_halt_exit;

`ifdef DMA_PARITY_ALIGN_EN
    // Free-running cycle parity; the copy may only start on an odd cycle.
    logic r_parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
        end
    end

    assign w_halt_exit = r_parity;
`else
    assign w_halt_exit = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_page_nxt  = r_page;
        bus_addr    = cpu_addr;
        bus_wdata   = cpu_wdata;
        bus_we      = cpu_we;
        case (r_state)
            S_IDLE: begin
                if (cpu_we && (cpu_addr == TRIG_ADDR)) begin
                    w_page_nxt  = cpu_wdata;
                    w_state_nxt = S_PENDING;
                end
            end
            S_PENDING: begin
                // Stall only once the CPU is in a read cycle; later triggers are ignored.
                if (!cpu_we) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                bus_we = 1'b0;
                if (w_halt_exit) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                bus_addr    = {r_page, r_idx[7:0]};
                bus_we      = 1'b0;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                bus_addr  = DEST_ADDR;
                bus_wdata = r_byte;
                bus_we    = 1'b1;
                if (r_idx == C_LAST_IDX) begin
                    w_idx_nxt   = 9'd0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 9'd1;
                    w_state_nxt = S_RD;
                end
            end
            S_DONE: begin
                bus_we      = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 9'd0;
            r_page      <= 8'd0;
            r_byte      <= 8'd0;
            r_cpu_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_page      <= w_page_nxt;
            r_cpu_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_PENDING);
            if (r_state == S_RD) begin
                r_byte <= mem_rdata;
            end
        end
    end

    assign cpu_ready = r_cpu_ready;
    assign dma_busy  = (r_state == S_HALT) || (r_state == S_RD) || (r_state == S_WR);
    assign dma_done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma_arbiter
// Description : Self-checking bench for oam_dma_arbiter (default and 1-byte
//               transfer builds, optional DMA_PARITY_ALIGN_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_arbiter;

    localparam int unsigned N0     = 256;
    localparam logic [15:0] C_TRIG = 16'h4014;
    localparam logic [15:0] C_DEST = 16'h2004;

    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [7:0]  d;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  mem_rdata;
    logic        cpu_ready;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        dma_busy;
    logic        dma_done;

    logic [15:0] cpu_addr_1;
    logic [7:0]  cpu_wdata_1;
    logic        cpu_we_1;
    logic [7:0]  mem_rdata_1;
    logic        cpu_ready_1;
    logic [15:0] bus_addr_1;
    logic [7:0]  bus_wdata_1;
    logic        bus_we_1;
    logic        dma_busy_1;
    logic        dma_done_1;

    logic [7:0] mem [0:65535];
    assign mem_rdata   = mem[bus_addr];
    assign mem_rdata_1 = mem[bus_addr_1];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DMA_PARITY_ALIGN_EN
    int unsigned cyc;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end
`endif

    oam_dma_arbiter u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .mem_rdata (mem_rdata),
        .cpu_ready (cpu_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .dma_busy  (dma_busy),
        .dma_done  (dma_done)
    );

    oam_dma_arbiter #(.XFER_LEN(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr_1),
        .cpu_wdata (cpu_wdata_1),
        .cpu_we    (cpu_we_1),
        .mem_rdata (mem_rdata_1),
        .cpu_ready (cpu_ready_1),
        .bus_addr  (bus_addr_1),
        .bus_wdata (bus_wdata_1),
        .bus_we    (bus_we_1),
        .dma_busy  (dma_busy_1),
        .dma_done  (dma_done_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_addr  = a;
        cpu_we    = w;
        cpu_wdata = d;
    endtask

    task automatic drive1(input logic [15:0] a, input logic w, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_addr_1  = a;
        cpu_we_1    = w;
        cpu_wdata_1 = d;
    endtask

    // Packed view of the CPU-side observables: {addr, we, wdata, ready, busy}.
    function automatic logic [31:0] view(input logic [15:0] a, input logic w, input logic [7:0] d,
                                         input logic r, input logic b);
        return 32'({a, w, d, r, b});
    endfunction

    // Trigger, n_wr pending writes (optionally with a second trigger), a read,
    // then the whole stall window compared against the expected beat list.
    task automatic run_transfer(input logic [7:0] page, input int n_wr, input bit second_trig);
        beat_t       q[$];
        int          stall, done_n, errs, exp_h;
        bit          fin;
        logic [15:0] a;
        logic [7:0]  d;
        beat_t       b;

        drive(C_TRIG, 1'b1, page);
        @(negedge clk);
        check("trig_pass", view(bus_addr, bus_we, bus_wdata, cpu_ready, dma_busy),
              view(C_TRIG, 1'b1, page, 1'b1, 1'b0));
        for (int i = 0; i < n_wr; i++) begin
            a = 16'h0300 + 16'(i);
            d = 8'($urandom);
            drive(a, 1'b1, d);
            @(negedge clk);
            check("pend_wr", view(bus_addr, bus_we, bus_wdata, cpu_ready, dma_busy),
                  view(a, 1'b1, d, 1'b1, 1'b0));
            if (second_trig && i == 1) begin
                drive(C_TRIG, 1'b1, page ^ 8'h05);
                @(negedge clk);
                check("pend_trig2", view(bus_addr, bus_we, bus_wdata, cpu_ready, dma_busy),
                      view(C_TRIG, 1'b1, page ^ 8'h05, 1'b1, 1'b0));
            end
        end
        a = 16'($urandom) | 16'h8000;
        d = 8'($urandom);
        drive(a, 1'b0, d);
        @(negedge clk);
        check("pend_rd", view(bus_addr, bus_we, bus_wdata, cpu_ready, dma_busy),
              view(a, 1'b0, d, 1'b1, 1'b0));
`ifdef DMA_PARITY_ALIGN_EN
        exp_h = (((cyc + 1) % 2) == 1) ? 1 : 2;
`else
        exp_h = 1;
`endif

        stall  = 0;
        done_n = 0;
        errs   = 0;
        fin    = 1'b0;
        for (int g = 0; g < 4 * int'(N0) + 20 && !fin; g++) begin
            drive(16'($urandom) | 16'h8000, 1'b1, 8'($urandom));
            @(negedge clk);
            if (!cpu_ready) stall++;
            if (dma_busy) q.push_back('{bus_addr, bus_we, bus_wdata});
            if (!dma_busy && !cpu_ready && bus_we) errs++;
            if (dma_done) done_n++;
            if (done_n > 0 && cpu_ready) begin
                fin = 1'b1;
                check("post_pass", view(bus_addr, bus_we, bus_wdata, cpu_ready, dma_done),
                      view(cpu_addr, 1'b1, cpu_wdata, 1'b1, 1'b0));
            end
        end
        check("xfer_finished", 32'(fin), 32'd1);
        check("stall_cycles", 32'(stall), 32'(2 * N0 + 1 + exp_h));
        check("done_pulses", 32'(done_n), 32'd1);
        check("busy_cycles", 32'(q.size()), 32'(exp_h + 2 * N0));
        if (q.size() == exp_h + 2 * int'(N0)) begin
            check("first_rd", 32'(q[exp_h].a), 32'({page, 8'h00}));
            for (int i = 0; i < exp_h; i++) if (q[i].we) errs++;
            for (int k = 0; k < int'(N0); k++) begin
                b = q[exp_h + 2 * k];
                if (b.a !== {page, 8'(k)} || b.we !== 1'b0) errs++;
                b = q[exp_h + 2 * k + 1];
                if (b.a !== C_DEST || b.we !== 1'b1 || b.d !== mem[{page, 8'(k)}]) errs++;
            end
        end else begin
            errs++;
        end
        check("beat_seq_errors", 32'(errs), 32'd0);
    endtask

    initial begin
        int          wc;
        bit          hit;
        logic [7:0]  p;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        reset       = 1'b1;
        cpu_addr    = 16'h1234;
        cpu_we      = 1'b1;
        cpu_wdata   = 8'hAA;
        cpu_addr_1  = 16'h8000;
        cpu_we_1    = 1'b0;
        cpu_wdata_1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_view", view(bus_addr, bus_we, bus_wdata, cpu_ready, dma_busy),
              view(16'h1234, 1'b1, 8'hAA, 1'b1, 1'b0));
        check("rst_done", 32'(dma_done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("pass_through", view(bus_addr, bus_we, bus_wdata, cpu_ready, dma_busy),
              view(16'h1234, 1'b1, 8'hAA, 1'b1, 1'b0));

        // Page 2 with a second trigger inside the pending window.
        run_transfer(8'h02, 3, 1'b1);
        run_transfer(8'($urandom), int'($urandom_range(0, 3)), 1'b0);
        run_transfer(8'($urandom), int'($urandom_range(0, 3)), 1'b1);

        // Reset in the WR beat of idx 100, then a fresh transfer.
        p = 8'($urandom);
        drive(C_TRIG, 1'b1, p);
        drive(16'h8000, 1'b0, 8'h00);
        wc  = 0;
        hit = 1'b0;
        for (int g = 0; g < 1000; g++) begin
            drive(16'($urandom) | 16'h8000, 1'b1, 8'($urandom));
            @(negedge clk);
            if (bus_we && dma_busy) begin
                if (wc == 100) begin
                    hit = 1'b1;
                    break;
                end
                wc++;
            end
        end
        check("reached_idx100", 32'(hit), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_we    = 1'b1;
        cpu_wdata = 8'hAA;
        @(negedge clk);
        check("midrst_view", view(bus_addr, bus_we, bus_wdata, cpu_ready, dma_busy),
              view(16'h1234, 1'b1, 8'hAA, 1'b1, 1'b0));
        check("midrst_done", 32'(dma_done), 32'd0);
        run_transfer(p + 8'd1, 1, 1'b0);

        // Single-byte build, page FF.
        drive1(C_TRIG, 1'b1, 8'hFF);
        @(negedge clk);
        check("len1_trig", view(bus_addr_1, bus_we_1, bus_wdata_1, cpu_ready_1, dma_busy_1),
              view(C_TRIG, 1'b1, 8'hFF, 1'b1, 1'b0));
        drive1(16'h8000, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            drive1(16'h8000, 1'b1, 8'h33);
            @(negedge clk);
            if (bus_addr_1 == 16'hFF00) break;
        end
        check("len1_rd", view(bus_addr_1, bus_we_1, 8'h00, cpu_ready_1, dma_busy_1),
              view(16'hFF00, 1'b0, 8'h00, 1'b0, 1'b1));
        drive1(16'h8000, 1'b1, 8'h33);
        @(negedge clk);
        check("len1_wr", view(bus_addr_1, bus_we_1, bus_wdata_1, cpu_ready_1, dma_busy_1),
              view(C_DEST, 1'b1, mem[16'hFF00], 1'b0, 1'b1));
        drive1(16'h8000, 1'b1, 8'h33);
        @(negedge clk);
        check("len1_done", view(16'h0000, bus_we_1, 8'h00, cpu_ready_1, dma_done_1),
              view(16'h0000, 1'b0, 8'h00, 1'b0, 1'b1));
        drive1(16'h8000, 1'b1, 8'h33);
        @(negedge clk);
        check("len1_idle", view(bus_addr_1, bus_we_1, bus_wdata_1, cpu_ready_1, dma_done_1),
              view(16'h8000, 1'b1, 8'h33, 1'b1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
